// File: rtl/sched_pkg.sv
// Shared definitions for the round-robin process scheduler.
//   - state_t      : scheduler FSM states
//   - wr_op_t      : process-table write-port operations
//   - proc_entry_t : one process-table slot {valid, pc, quantum}
//   - eff_quantum  : maps a requested quantum of 0 to the default quantum
package sched_pkg;

  localparam int unsigned PID_W_DEF   = 2;
  localparam logic [31:0] DEF_QUANTUM = 32'd1000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAVE,
    S_SEARCH,
    S_GRANT
  } state_t;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_CREATE,
    WR_SAVE,
    WR_RETIRE
  } wr_op_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] quantum;
  } proc_entry_t;

  function automatic logic [31:0] eff_quantum(input logic [31:0] q, input logic [31:0] dflt);
    return (q == 32'd0) ? dflt : q;
  endfunction

endpackage

// File: rtl/proc_table.sv
// NPROC-entry process table.
//   clk, rst          : clock, asynchronous active-high reset (clears every slot)
//   wr_op/wr_pid      : single write port; create writes a whole slot, save writes
//   wr_pc/wr_quantum  :   only the PC, retire clears only the valid bit
//   search_pid/_valid : combinational read of a slot's valid bit
//   grant_pid/_entry  : combinational read of a whole slot
//   free_pid          : lowest-index free slot (meaningless when full)
//   full / empty      : all slots valid / no slot valid
module proc_table
  import sched_pkg::*;
#(
  parameter int unsigned PID_W = PID_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  wr_op_t           wr_op,
  input  logic [PID_W-1:0] wr_pid,
  input  logic [31:0]      wr_pc,
  input  logic [31:0]      wr_quantum,
  input  logic [PID_W-1:0] search_pid,
  output logic             search_valid,
  input  logic [PID_W-1:0] grant_pid,
  output proc_entry_t      grant_entry,
  output logic [PID_W-1:0] free_pid,
  output logic             full,
  output logic             empty
);

  localparam int unsigned NPROC = 1 << PID_W;

  proc_entry_t entries [NPROC];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPROC; i++) begin
        entries[i] <= '0;
      end
    end else begin
      unique case (wr_op)
        WR_CREATE: entries[wr_pid] <= '{valid: 1'b1, pc: wr_pc, quantum: wr_quantum};
        WR_SAVE:   entries[wr_pid].pc <= wr_pc;
        WR_RETIRE: entries[wr_pid].valid <= 1'b0;
        default:   ;
      endcase
    end
  end

  assign search_valid = entries[search_pid].valid;
  assign grant_entry  = entries[grant_pid];

  // Descending scan so the last assignment wins: the lowest free index.
  always_comb begin
    free_pid = '0;
    full     = 1'b1;
    empty    = 1'b1;
    for (int i = NPROC - 1; i >= 0; i--) begin
      if (!entries[i].valid) begin
        free_pid = PID_W'(i);
        full     = 1'b0;
      end else begin
        empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin process scheduler beside the BIOS controller.
//   clk, rst                          : clock, asynchronous active-high reset
//   create_req/pc/quantum             : register a new process (quantum 0 -> default)
//   create_ack/err/pid                : one-cycle create result, slot allocated
//   switch_req/cur_pc/cur_done        : context-switch request from the BIOS
//   switch_valid/next_pid/pc/quantum  : one-cycle pulse with the selected process
//   idle                              : no runnable process in the table
//   busy                              : a switch is in progress
//   table_full                        : every slot is valid
module process_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned PID_W           = PID_W_DEF,
  parameter logic [31:0] DEFAULT_QUANTUM = DEF_QUANTUM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             create_req,
  input  logic [31:0]      create_pc,
  input  logic [31:0]      create_quantum,
  output logic             create_ack,
  output logic             create_err,
  output logic [PID_W-1:0] create_pid,
  input  logic             switch_req,
  input  logic [31:0]      cur_pc,
  input  logic             cur_done,
  output logic             switch_valid,
  output logic [PID_W-1:0] next_pid,
  output logic [31:0]      next_pc,
  output logic [31:0]      next_quantum,
  output logic             idle,
  output logic             busy,
  output logic             table_full
);

  localparam int unsigned NPROC = 1 << PID_W;

  state_t           state;
  logic             running;
  logic [PID_W-1:0] cur_pid;
  logic [PID_W-1:0] cand;
  logic [PID_W-1:0] exam_cnt;
  logic [PID_W-1:0] sel;
  logic [31:0]      lat_pc;
  logic             lat_done;

  wr_op_t           wr_op;
  logic [PID_W-1:0] wr_pid;
  logic [31:0]      wr_pc;
  logic [31:0]      wr_quantum;
  logic             search_valid;
  proc_entry_t      grant_entry;
  logic [PID_W-1:0] free_pid;
  logic             full;
  logic             empty;

  proc_table #(
    .PID_W (PID_W)
  ) u_table (
    .clk          (clk),
    .rst          (rst),
    .wr_op        (wr_op),
    .wr_pid       (wr_pid),
    .wr_pc        (wr_pc),
    .wr_quantum   (wr_quantum),
    .search_pid   (cand),
    .search_valid (search_valid),
    .grant_pid    (sel),
    .grant_entry  (grant_entry),
    .free_pid     (free_pid),
    .full         (full),
    .empty        (empty)
  );

  // Both flags come straight from the table registers, so they follow every table write.
  assign table_full = full;
  assign idle       = empty;

  always_comb begin
    wr_op      = WR_NONE;
    wr_pid     = cur_pid;
    wr_pc      = lat_pc;
    wr_quantum = eff_quantum(create_quantum, DEFAULT_QUANTUM);
    unique case (state)
      S_IDLE: begin
        if (!switch_req && create_req && !full) begin
          wr_op  = WR_CREATE;
          wr_pid = free_pid;
          wr_pc  = create_pc;
        end
      end
      S_SAVE: begin
        if (running) begin
          wr_op = lat_done ? WR_RETIRE : WR_SAVE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      running      <= 1'b0;
      cur_pid      <= '0;
      cand         <= '0;
      exam_cnt     <= '0;
      sel          <= '0;
      lat_pc       <= '0;
      lat_done     <= 1'b0;
      create_ack   <= 1'b0;
      create_err   <= 1'b0;
      create_pid   <= '0;
      switch_valid <= 1'b0;
      next_pid     <= '0;
      next_pc      <= '0;
      next_quantum <= '0;
      busy         <= 1'b0;
    end else begin
      create_ack   <= 1'b0;
      create_err   <= 1'b0;
      switch_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (switch_req) begin
            lat_pc   <= cur_pc;
            lat_done <= cur_done;
            busy     <= 1'b1;
            state    <= S_SAVE;
          end else if (create_req) begin
            if (!full) begin
              create_ack <= 1'b1;
              create_pid <= free_pid;
            end else begin
              create_err <= 1'b1;
            end
          end
        end
        S_SAVE: begin
          // Start after the preempted slot so it is examined last.
          cand     <= cur_pid + PID_W'(1);
          exam_cnt <= '0;
          state    <= S_SEARCH;
        end
        S_SEARCH: begin
          if (search_valid) begin
            sel   <= cand;
            state <= S_GRANT;
          end else if (exam_cnt == PID_W'(NPROC - 1)) begin
            state <= S_GRANT;
          end else begin
            cand     <= cand + PID_W'(1);
            exam_cnt <= exam_cnt + PID_W'(1);
          end
        end
        S_GRANT: begin
          switch_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= S_IDLE;
          // The table is frozen while busy, so an exhausted search means every slot is
          // invalid and the stale sel reads an invalid entry.
          if (grant_entry.valid) begin
            next_pid     <= sel;
            next_pc      <= grant_entry.pc;
            next_quantum <= grant_entry.quantum;
            running      <= 1'b1;
            cur_pid      <= sel;
          end else begin
            running <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: directed literal scenarios followed by random traffic,
// all checked every cycle against an event-level model of the scheduler.
module tb_process_scheduler;

  localparam int NPROC = 4;
  localparam logic [31:0] DQ = 32'd1000;

  logic        clk;
  logic        rst;
  logic        create_req;
  logic [31:0] create_pc;
  logic [31:0] create_quantum;
  logic        create_ack;
  logic        create_err;
  logic [1:0]  create_pid;
  logic        switch_req;
  logic [31:0] cur_pc;
  logic        cur_done;
  logic        switch_valid;
  logic [1:0]  next_pid;
  logic [31:0] next_pc;
  logic [31:0] next_quantum;
  logic        idle;
  logic        busy;
  logic        table_full;

  process_scheduler #(
    .PID_W           (2),
    .DEFAULT_QUANTUM (DQ)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .create_req     (create_req),
    .create_pc      (create_pc),
    .create_quantum (create_quantum),
    .create_ack     (create_ack),
    .create_err     (create_err),
    .create_pid     (create_pid),
    .switch_req     (switch_req),
    .cur_pc         (cur_pc),
    .cur_done       (cur_done),
    .switch_valid   (switch_valid),
    .next_pid       (next_pid),
    .next_pc        (next_pc),
    .next_quantum   (next_quantum),
    .idle           (idle),
    .busy           (busy),
    .table_full     (table_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [NPROC];
  logic [31:0] m_pc    [NPROC];
  logic [31:0] m_q     [NPROC];
  bit          m_running;
  int          m_cur;
  int          cnt;       // edges left until the grant pulse
  int          m_j;       // examined position of the winner (NPROC when none)
  int          p_kind;    // pending table update: 0 none, 1 save, 2 retire
  int          p_pid;
  logic [31:0] p_pc;
  bit          g_found;
  int          g_pid;
  bit          e_ack, e_err, e_sv, e_busy;
  int          e_pid;
  int          e_npid;
  logic [31:0] e_npc, e_nq;
  bit          chk_en = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < NPROC; i++) begin
      m_valid[i] = 1'b0;
      m_pc[i]    = '0;
      m_q[i]     = '0;
    end
    m_running = 1'b0; m_cur = 0; cnt = 0; m_j = 0; p_kind = 0;
    e_ack = 0; e_err = 0; e_sv = 0; e_busy = 0; e_pid = 0;
    e_npid = 0; e_npc = '0; e_nq = '0;
  endtask

  function automatic bit m_full();
    for (int i = 0; i < NPROC; i++) if (!m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_empty();
    for (int i = 0; i < NPROC; i++) if (m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit tv [NPROC];
    if (rst) begin
      model_reset();
      return;
    end
    e_ack = 0; e_err = 0; e_sv = 0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 1 + m_j) begin
        if (p_kind == 1) m_pc[p_pid] = p_pc;
        if (p_kind == 2) m_valid[p_pid] = 1'b0;
      end
      if (cnt == 0) begin
        e_sv = 1;
        if (g_found) begin
          e_npid = g_pid; e_npc = m_pc[g_pid]; e_nq = m_q[g_pid];
          m_running = 1'b1; m_cur = g_pid;
        end else begin
          m_running = 1'b0;
        end
      end
    end else if (switch_req) begin
      p_kind = 0;
      for (int i = 0; i < NPROC; i++) tv[i] = m_valid[i];
      if (m_running) begin
        p_pid = m_cur;
        p_pc  = cur_pc;
        if (cur_done) begin p_kind = 2; tv[m_cur] = 1'b0; end
        else p_kind = 1;
      end
      g_found = 0; m_j = NPROC;
      for (int k = 1; k <= NPROC; k++) begin
        if (!g_found && tv[(m_cur + k) % NPROC]) begin
          g_found = 1; g_pid = (m_cur + k) % NPROC; m_j = k;
        end
      end
      cnt = 2 + m_j;
    end else if (create_req) begin
      if (m_full()) e_err = 1;
      else begin
        for (int i = NPROC - 1; i >= 0; i--) if (!m_valid[i]) e_pid = i;
        m_valid[e_pid] = 1'b1;
        m_pc[e_pid]    = create_pc;
        m_q[e_pid]     = (create_quantum == 0) ? DQ : create_quantum;
        e_ack = 1;
      end
    end
    e_busy = (cnt > 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("m_switch_valid", 32'(switch_valid), 32'(e_sv));
        check("m_busy", 32'(busy), 32'(e_busy));
        check("m_create_ack", 32'(create_ack), 32'(e_ack));
        check("m_create_err", 32'(create_err), 32'(e_err));
        check("m_idle", 32'(idle), 32'(m_empty()));
        check("m_table_full", 32'(table_full), 32'(m_full()));
        check("m_next_pid", 32'(next_pid), 32'(e_npid));
        check("m_next_pc", next_pc, e_npc);
        check("m_next_quantum", next_quantum, e_nq);
        if (e_ack) check("m_create_pid", 32'(create_pid), 32'(e_pid));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_create(input logic [31:0] pc, input logic [31:0] q,
                           input bit exp_ok, input int exp_pid);
    create_req = 1'b1; create_pc = pc; create_quantum = q;
    tick();
    create_req = 1'b0;
    check("create_ack", 32'(create_ack), 32'(exp_ok));
    check("create_err", 32'(create_err), 32'(!exp_ok));
    if (exp_ok) check("create_pid", 32'(create_pid), 32'(exp_pid));
  endtask

  task automatic do_switch(input logic [31:0] pc, input bit done, input int exp_lat,
                           input int exp_pid, input logic [31:0] exp_pc,
                           input logic [31:0] exp_q, input bit exp_idle);
    int n = 0;
    switch_req = 1'b1; cur_pc = pc; cur_done = done;
    tick();
    switch_req = 1'b0; cur_done = 1'b0;
    while (n < 20 && !switch_valid) begin
      tick();
      n++;
    end
    check("switch_latency", 32'(n), 32'(exp_lat));
    check("sw_idle", 32'(idle), 32'(exp_idle));
    check("sw_next_pid", 32'(next_pid), 32'(exp_pid));
    check("sw_next_pc", next_pc, exp_pc);
    check("sw_next_quantum", next_quantum, exp_q);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    rst = 1'b1; create_req = 1'b0; create_pc = '0; create_quantum = '0;
    switch_req = 1'b0; cur_pc = '0; cur_done = 1'b0;
    tick(); tick();
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_next_pc", next_pc, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Empty table: exhaustive search of all four slots.
    do_switch(32'h0, 1'b0, 6, 0, 32'h0, 32'h0, 1'b1);

    // One process; search starts after cur_pid 0, so slot 0 is examined fourth.
    do_create(32'h100, 32'h0, 1'b1, 0);
    do_switch(32'h0, 1'b0, 6, 0, 32'h100, DQ, 1'b0);

    // Round robin with context save and wrap.
    do_create(32'h200, 32'd5, 1'b1, 1);
    do_create(32'h300, 32'd7, 1'b1, 2);
    do_switch(32'h140, 1'b0, 3, 1, 32'h200, 32'd5, 1'b0);
    do_switch(32'h210, 1'b0, 3, 2, 32'h300, 32'd7, 1'b0);
    do_switch(32'h310, 1'b0, 4, 0, 32'h140, DQ, 1'b0);

    // Full table, refused create, retire frees a slot.
    do_create(32'h400, 32'd9, 1'b1, 3);
    check("full_after_fill", 32'(table_full), 32'd1);
    do_create(32'h500, 32'd1, 1'b0, 0);
    do_switch(32'h150, 1'b0, 3, 1, 32'h210, 32'd5, 1'b0);
    do_switch(32'h220, 1'b0, 3, 2, 32'h310, 32'd7, 1'b0);
    do_switch(32'h320, 1'b0, 3, 3, 32'h400, 32'd9, 1'b0);
    do_switch(32'h999, 1'b1, 3, 0, 32'h150, DQ, 1'b0);
    check("full_after_retire", 32'(table_full), 32'd0);

    // Create and switch together: the create is dropped.
    create_req = 1'b1; create_pc = 32'h700; create_quantum = 32'd3;
    switch_req = 1'b1; cur_pc = 32'h160; cur_done = 1'b0;
    tick();
    create_req = 1'b0; switch_req = 1'b0;
    check("dropped_ack", 32'(create_ack), 32'd0);
    check("dropped_err", 32'(create_err), 32'd0);
    seen = 0;
    while (seen < 20 && !switch_valid) begin tick(); seen++; end
    check("dropped_sw_lat", 32'(seen), 32'd3);
    check("dropped_sw_pc", next_pc, 32'h220);
    do_create(32'h600, 32'h0, 1'b1, 3);

    // Reset in the middle of a search.
    switch_req = 1'b1; cur_pc = 32'h230; tick();
    switch_req = 1'b0; tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_idle", 32'(idle), 32'd1);
    check("midrst_sv", 32'(switch_valid), 32'd0);
    check("midrst_next_pc", next_pc, 32'd0);
    check("midrst_full", 32'(table_full), 32'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (switch_valid) seen++;
    end
    check("midrst_no_sv", 32'(seen), 32'd0);
    do_switch(32'h0, 1'b0, 6, 0, 32'h0, 32'h0, 1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      switch_req     = ($urandom_range(0, 99) < 15);
      create_req     = ($urandom_range(0, 99) < 25);
      create_pc      = $urandom;
      create_quantum = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(1, 5000));
      cur_pc         = $urandom;
      cur_done       = ($urandom_range(0, 3) == 0);
      rst            = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; switch_req = 1'b0; create_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
